pulse_stretch: RTL and testbench
================================

Name: pulse_stretch

Overview:
- Converts single-cycle event pulses back into level signals. Each accepted event drives `out` high for a programmable number of cycles.
- This is the inverse of the level-to-pulse conditioner used on device-side control inputs. It sits on the same control-input path in bp_me dev logic, on the device-facing side.
- Events that arrive while an output window is active are either counted and replayed later, or they extend the current window, depending on `retrig`.

Parameters:
- LEN_W, 8: width of the `len` input and of the hold counter. Maximum hold is 2^LEN_W-1 cycles.
- PEND_W, 4: width of the pending-event counter. It saturates at 2^PEND_W-1.
- GAP, 1: number of forced-low cycles between back-to-back replayed windows. Legal range is 0..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in  in  1  event input. Every cycle with `in`=1 is one event.
- len  in  LEN_W  hold length L. It is sampled at the start of each window; 0 is treated as 1.
- retrig  in  1  1 = an event during HOLD restarts the window; 0 = the event is queued as pending.
- clr_ovf  in  1  one-cycle pulse that clears `overflow`.
- out  out  1  stretched level.
- busy  out  1  high when state != IDLE.
- pending  out  PEND_W  number of queued events not yet emitted.
- overflow  out  1  sticky flag: an event was dropped because `pending` was saturated.

Behaviour:
- Reset (asynchronous assert, synchronous deassert assumed by the system):
  - state=IDLE, out=0, busy=0, pending=0, overflow=0, hold counter=0.
  - Asserting reset mid-window drops `out` low immediately and discards all pending events.
- States: IDLE, HOLD, GAP_S. `out` is registered and equals 1 exactly in HOLD.
- IDLE:
  - If in=1: latch Lq=max(len,1), load counter=Lq-1, go to HOLD.
  - Latency: `in` high at edge t gives `out` high from t+1 through t+Lq inclusive.
- HOLD, counter>0: decrement each cycle.
- HOLD, counter==0 (last high cycle), exit rules in priority order:
  - in=1 and retrig=1: reload counter from current len, stay in HOLD.
  - pending>0 (after counting this cycle's event) and GAP==0: decrement pending, reload Lq from len, stay in HOLD. The windows merge into one level.
  - pending>0 and GAP>0: go to GAP_S.
  - Otherwise: go to IDLE. `out` falls next cycle.
- Events during HOLD when not at the last cycle:
  - retrig=1: reload counter=max(len,1)-1. This restarts, it does not add to the remaining count. `pending` is unchanged.
  - retrig=0: pending+1.
- Events during GAP_S and on the last HOLD cycle with retrig=0 also count into pending.
- GAP_S:
  - `out`=0 for exactly GAP cycles (internal gap counter).
  - Then decrement pending, latch Lq from len, go to HOLD.
- Pending arithmetic:
  - A simultaneous increment (event) and decrement (window start) leaves the value unchanged.
  - An increment at 2^PEND_W-1 without a simultaneous decrement is dropped and sets overflow=1.
- Overflow:
  - `overflow` clears on clr_ovf=1.
  - If clr_ovf and a new overflow occur in the same cycle, set wins.
- `len` changes mid-window do not affect the active window unless a retrigger reload happens.
- `busy` is high in HOLD and GAP_S. `busy` falls in the same cycle that `out` falls to return to IDLE.

Test Plan:
- Reset, len=3, single `in` pulse at edge 10 → out=1 at edges 11,12,13, out=0 at 14, busy mirrors out, pending stays 0.
- len=0, single pulse → out high exactly 1 cycle.
- retrig=0, GAP=1, len=4, pulses at edges 10 and 12 → out high 11-14, low at 15, high 16-19, pending=1 during 12-15, 0 from 16.
- retrig=1, len=4, pulses at 10 and 12 → out high 11-16 continuous, then low, pending stays 0.
- PEND_W=2, retrig=0, len=20, `in` held high for 6 cycles → pending saturates at 3, overflow=1, four windows emitted in total. clr_ovf pulse clears overflow; clr_ovf and a new overflow in the same cycle leaves overflow=1.
- GAP=0, two queued events, len=2 → out high for 6 consecutive cycles. Assert reset_n=0 mid-window → out=0, pending=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pulse_stretch.sv
// Pulse-to-level stretcher: each accepted event holds out_o high for a programmable window.
// Events seen while a window is active either restart it or are queued for replay.
module pulse_stretch #(
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned PEND_W = 4,
    parameter int unsigned GAP    = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              retrig_i,
    input  logic              clr_ovf_i,
    output logic              out_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pending_o,
    output logic              overflow_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHold = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    localparam logic [PEND_W-1:0] PendMax = '1;
    localparam logic [7:0]        GapLoad = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

    logic [1:0]        state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        gap_q, gap_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;

    logic [LEN_W-1:0]  len_m1;
    logic              inc, dec, ovf_set;

    // A zero length behaves as a one-cycle window.
    assign len_m1 = (len_i == '0) ? '0 : len_i - LEN_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        inc     = 1'b0;
        dec     = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_i) begin
                    state_d = StHold;
                    cnt_d   = len_m1;
                end
            end
            StHold: begin
                inc = in_i & ~retrig_i;
                if (cnt_q != '0) begin
                    cnt_d = (in_i && retrig_i) ? len_m1 : cnt_q - LEN_W'(1);
                end else if (in_i && retrig_i) begin
                    cnt_d = len_m1;
                end else if (pend_q != '0 || inc) begin
                    // Queued work on the last cycle: merge windows or insert the low gap.
                    if (GAP == 0) begin
                        dec   = 1'b1;
                        cnt_d = len_m1;
                    end else begin
                        state_d = StGap;
                        gap_d   = GapLoad;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StGap: begin
                inc = in_i;
                if (gap_q != '0) begin
                    gap_d = gap_q - 8'd1;
                end else begin
                    dec     = 1'b1;
                    cnt_d   = len_m1;
                    state_d = StHold;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (inc && !dec) begin
            if (pend_q == PendMax) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - PEND_W'(1);
        end
        // A new overflow takes precedence over a simultaneous clear.
        ovf_d = ovf_set | (ovf_q & ~clr_ovf_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            gap_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_o      = (state_q == StHold);
    assign busy_o     = (state_q != StIdle);
    assign pending_o  = pend_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch: one instance with a one-cycle gap, one with no gap.
module tb_pulse_stretch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_s, retrig_s, clr_s;
    logic [7:0] len_s;

    logic       out_a, busy_a, ovf_a;
    logic [1:0] pend_a;
    logic       out_b, busy_b, ovf_b;
    logic [1:0] pend_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pulse_stretch #(.LEN_W(8), .PEND_W(2), .GAP(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .in_i(in_s), .len_i(len_s), .retrig_i(retrig_s),
        .clr_ovf_i(clr_s), .out_o(out_a), .busy_o(busy_a), .pending_o(pend_a),
        .overflow_o(ovf_a)
    );

    pulse_stretch #(.LEN_W(8), .PEND_W(2), .GAP(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .in_i(in_s), .len_i(len_s), .retrig_i(retrig_s),
        .clr_ovf_i(clr_s), .out_o(out_b), .busy_o(busy_b), .pending_o(pend_b),
        .overflow_o(ovf_b)
    );

    typedef struct {
        logic       in;
        logic [7:0] len;
        logic       retrig;
        logic       clr;
        logic       eout;
        logic       ebusy;
        logic [1:0] epend;
        logic       eovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic i, input logic [7:0] l, input logic r, input logic c,
                       input logic o, input logic b, input logic [1:0] p, input logic v);
        vec_t t;
        t.in = i; t.len = l; t.retrig = r; t.clr = c;
        t.eout = o; t.ebusy = b; t.epend = p; t.eovf = v;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs are set just after an edge; outputs are sampled 1 time unit after the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_s = 1'b0; len_s = 8'd0; retrig_s = 1'b0; clr_s = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int hi;
        int wins;
        logic prev;
        logic done;

        do_reset();
        chk("reset.out", out_a, 0);
        chk("reset.busy", busy_a, 0);
        chk("reset.pend", pend_a, 0);
        chk("reset.ovf", ovf_a, 0);

        // Single pulse, len=3, len altered mid-window without effect
        add(1, 3, 0, 0, 1, 1, 0, 0);
        add(0, 7, 0, 0, 1, 1, 0, 0);
        add(0, 7, 0, 0, 1, 1, 0, 0);
        add(0, 3, 0, 0, 0, 0, 0, 0);
        add(0, 3, 0, 0, 0, 0, 0, 0);
        // len=0 acts as 1
        add(1, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // retrig=0, len=4, second event queued then replayed after one gap cycle
        add(1, 4, 0, 0, 1, 1, 0, 0);
        add(0, 4, 0, 0, 1, 1, 0, 0);
        add(1, 4, 0, 0, 1, 1, 1, 0);
        add(0, 4, 0, 0, 1, 1, 1, 0);
        add(0, 4, 0, 0, 0, 1, 1, 0);
        add(0, 4, 0, 0, 1, 1, 0, 0);
        add(0, 4, 0, 0, 1, 1, 0, 0);
        add(0, 4, 0, 0, 1, 1, 0, 0);
        add(0, 4, 0, 0, 1, 1, 0, 0);
        add(0, 4, 0, 0, 0, 0, 0, 0);
        // retrig=1, len=4, second event restarts the window
        add(1, 4, 1, 0, 1, 1, 0, 0);
        add(0, 4, 1, 0, 1, 1, 0, 0);
        add(1, 4, 1, 0, 1, 1, 0, 0);
        add(0, 9, 1, 0, 1, 1, 0, 0);
        add(0, 9, 1, 0, 1, 1, 0, 0);
        add(0, 9, 1, 0, 1, 1, 0, 0);
        add(0, 9, 1, 0, 0, 0, 0, 0);
        // Events on the last HOLD cycle and in the gap (simultaneous inc/dec)
        add(1, 2, 0, 0, 1, 1, 0, 0);
        add(0, 2, 0, 0, 1, 1, 0, 0);
        add(1, 2, 0, 0, 0, 1, 1, 0);
        add(1, 2, 0, 0, 1, 1, 1, 0);
        add(0, 2, 0, 0, 1, 1, 1, 0);
        add(0, 2, 0, 0, 0, 1, 1, 0);
        add(0, 2, 0, 0, 1, 1, 0, 0);
        add(0, 2, 0, 0, 1, 1, 0, 0);
        add(0, 2, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            in_s = vecs[i].in; len_s = vecs[i].len;
            retrig_s = vecs[i].retrig; clr_s = vecs[i].clr;
            step();
            chk($sformatf("vec%0d.out", i), out_a, vecs[i].eout);
            chk($sformatf("vec%0d.busy", i), busy_a, vecs[i].ebusy);
            chk($sformatf("vec%0d.pend", i), pend_a, vecs[i].epend);
            chk($sformatf("vec%0d.ovf", i), ovf_a, vecs[i].eovf);
        end

        // Saturation: in held for 6 cycles with len=20, pending caps at 3
        do_reset();
        len_s = 8'd20; in_s = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 3) begin
                chk("sat.pend3", pend_a, 3);
                chk("sat.noovf", ovf_a, 0);
            end
        end
        chk("sat.pend", pend_a, 3);
        chk("sat.ovf", ovf_a, 1);
        in_s = 1'b0; clr_s = 1'b1;
        step();
        chk("clr.ovf", ovf_a, 0);
        in_s = 1'b1; clr_s = 1'b1;
        step();
        chk("clrset.ovf", ovf_a, 1);
        chk("clrset.pend", pend_a, 3);
        in_s = 1'b0; clr_s = 1'b0;
        step();
        hi = 0; wins = 1; prev = out_a; done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            if (out_a) hi++;
            if (out_a && !prev) wins++;
            prev = out_a;
            if (!busy_a) done = 1'b1;
        end
        chk("sat.done", done, 1);
        chk("sat.windows", wins, 4);
        chk("sat.hicycles", hi, 71);
        chk("sat.pendend", pend_a, 0);
        chk("sat.ovfsticky", ovf_a, 1);

        // GAP=0: three events with len=2 merge into one 6-cycle level
        do_reset();
        len_s = 8'd2;
        for (int i = 0; i < 7; i++) begin
            in_s = (i < 3);
            step();
            chk($sformatf("gap0.out%0d", i), out_b, (i < 6) ? 1 : 0);
            if (i == 1) chk("gap0.pend1", pend_b, 1);
        end
        chk("gap0.pendend", pend_b, 0);

        // Asynchronous reset mid-window clears output and queue without a clock edge
        do_reset();
        len_s = 8'd2;
        in_s = 1'b1;
        step();
        step();
        step();
        in_s = 1'b0;
        chk("arst.pre_out", out_b, 1);
        chk("arst.pre_pend", pend_b, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out", out_b, 0);
        chk("arst.pend", pend_b, 0);
        chk("arst.busy", busy_b, 0);
        chk("arst.out_a", out_a, 0);
        step();
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
